loopback_err_checker: RTL and testbench

LOOPBACK_ERR_CHECKER -- requirements
Module: loopback_err_checker

---
 rtl/loopback_pkg.sv | 18 +
 rtl/sat_counter.sv | 32 +++
 rtl/loopback_err_checker.sv | 115 +++++++++++
 tb/tb_loopback_err_checker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/loopback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : loopback_pkg                                              |
// | Purpose  : Shared state encoding and defaults for the loopback check |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package loopback_pkg;

    localparam int c_data_width_def  = 32;
    localparam int c_loss_thresh_def = 8;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lb_state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sat_counter                                               |
// | Purpose  : Registered up-counter that sticks at all-ones; clr wins   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/loopback_err_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : loopback_err_checker                                      |
// | Purpose  : Locks to an incrementing loopback pattern, counts errors  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module loopback_err_checker
    import loopback_pkg::*;
#(
    parameter int DATA_WIDTH  = c_data_width_def,
    parameter int LOSS_THRESH = c_loss_thresh_def
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_sync,
    input  logic                  clr,
    output logic [31:0]           err_cnt,
    output logic [15:0]           loss_cnt,
    output logic                  locked
);

    localparam int c_run_w = $clog2(LOSS_THRESH + 1);
    localparam logic [c_run_w-1:0] c_run_last = c_run_w'(LOSS_THRESH - 1);

    lb_state_e               r_state;
    lb_state_e               w_state_next;
    logic [DATA_WIDTH-1:0]   r_expected;
    logic [c_run_w-1:0]      r_run;
    logic                    r_locked;

    logic w_sync_hit;
    logic w_check;
    logic w_mismatch;
    logic w_loss;

    always_comb begin
        w_sync_hit   = 1'b0;
        w_check      = 1'b0;
        w_mismatch   = 1'b0;
        w_loss       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            HUNT: begin
                w_sync_hit = rx_valid && rx_sync;
                if (w_sync_hit) begin
                    w_state_next = LOCKED;
                end
            end
            LOCKED: begin
                // rx_sync is deliberately ignored here: the word is plain data
                w_check    = rx_valid;
                w_mismatch = rx_valid && (rx_data != r_expected);
                w_loss     = w_mismatch && (r_run == c_run_last);
                if (w_loss) begin
                    w_state_next = HUNT;
                end
            end
            default: w_state_next = HUNT;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_state    <= HUNT;
            r_locked   <= 1'b0;
            r_expected <= '0;
        end else begin
            r_state  <= w_state_next;
            r_locked <= (w_state_next == LOCKED);
            if (w_sync_hit) begin
                r_expected <= rx_data + 1'b1;
            end else if (w_check) begin
                r_expected <= r_expected + 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_run <= '0;
        end else if (clr || w_loss) begin
            r_run <= '0;
        end else if (w_mismatch) begin
            r_run <= r_run + 1'b1;
        end else if (w_check) begin
            r_run <= '0;
        end
    end

    sat_counter #(
        .WIDTH (32)
    ) u_err_cnt (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .inc   (w_mismatch),
        .clr   (clr),
        .count (err_cnt)
    );

    sat_counter #(
        .WIDTH (16)
    ) u_loss_cnt (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .inc   (w_loss),
        .clr   (clr),
        .count (loss_cnt)
    );

    assign locked = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_loopback_err_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_loopback_err_checker                                   |
// | Purpose  : Directed self-checking bench for loopback_err_checker     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_loopback_err_checker;

    logic        user_clk = 1'b0;
    logic        user_rst_n;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_sync;
    logic        clr;
    logic [31:0] err_cnt;
    logic [15:0] loss_cnt;
    logic        locked;

    logic        sc_rst_n;
    logic        sc_inc;
    logic        sc_clr;
    logic [2:0]  sc_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 user_clk = ~user_clk;

    loopback_err_checker #(
        .DATA_WIDTH  (32),
        .LOSS_THRESH (8)
    ) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sync    (rx_sync),
        .clr        (clr),
        .err_cnt    (err_cnt),
        .loss_cnt   (loss_cnt),
        .locked     (locked)
    );

    // Narrow instance so saturation is reachable in a few cycles
    sat_counter #(
        .WIDTH (3)
    ) u_sat3 (
        .clk   (user_clk),
        .rst_n (sc_rst_n),
        .inc   (sc_inc),
        .clr   (sc_clr),
        .count (sc_count)
    );

    task automatic cyc(input logic v, input logic s, input logic [31:0] d, input logic c);
        rx_valid = v;
        rx_sync  = s;
        rx_data  = d;
        clr      = c;
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] e_err,
                       input logic [15:0] e_loss, input logic e_lock);
        n_cmp++;
        assert (err_cnt === e_err) else begin
            n_bad++;
            $error("FAIL %s err_cnt: observed %0h expected %0h", tag, err_cnt, e_err);
        end
        n_cmp++;
        assert (loss_cnt === e_loss) else begin
            n_bad++;
            $error("FAIL %s loss_cnt: observed %0h expected %0h", tag, loss_cnt, e_loss);
        end
        n_cmp++;
        assert (locked === e_lock) else begin
            n_bad++;
            $error("FAIL %s locked: observed %0b expected %0b", tag, locked, e_lock);
        end
    endtask

    task automatic chk_sat(input string tag, input logic [2:0] e_cnt);
        n_cmp++;
        assert (sc_count === e_cnt) else begin
            n_bad++;
            $error("FAIL %s sat_count: observed %0d expected %0d", tag, sc_count, e_cnt);
        end
    endtask

    initial begin
        user_rst_n = 1'b0;
        sc_rst_n   = 1'b0;
        sc_inc     = 1'b0;
        sc_clr     = 1'b0;
        cyc(0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 0);
        chk("reset", 32'd0, 16'd0, 1'b0);
        user_rst_n = 1'b1;
        sc_rst_n   = 1'b1;

        // Hunting: non-sync words and unqualified sync are ignored
        cyc(1, 0, 32'h10, 0);
        cyc(1, 0, 32'h11, 0);
        chk("hunt_nosync", 32'd0, 16'd0, 1'b0);
        cyc(0, 1, 32'h10, 0);
        chk("sync_novalid", 32'd0, 16'd0, 1'b0);

        // Lock on 0x10, clean stream 0x11..0x20
        cyc(1, 1, 32'h10, 0);
        chk("sync_lock", 32'd0, 16'd0, 1'b1);
        for (int i = 32'h11; i <= 32'h20; i++) cyc(1, 0, 32'(i), 0);
        chk("stream_clean", 32'd0, 16'd0, 1'b1);

        // Idle cycle holds expected at 0x21
        cyc(0, 0, 32'hBAD, 0);
        cyc(1, 0, 32'h21, 0);
        chk("idle_hold", 32'd0, 16'd0, 1'b1);

        // One corrupted word in place of 0x25
        cyc(1, 0, 32'h22, 0);
        cyc(1, 0, 32'h23, 0);
        cyc(1, 0, 32'h24, 0);
        cyc(1, 0, 32'hDEADBEEF, 0);
        chk("bad_word", 32'd1, 16'd0, 1'b1);
        cyc(1, 0, 32'h26, 0);
        cyc(1, 0, 32'h27, 0);
        cyc(1, 0, 32'h28, 0);
        chk("after_bad", 32'd1, 16'd0, 1'b1);

        cyc(0, 0, 32'h0, 1);
        chk("clr_idle", 32'd0, 16'd0, 1'b1);

        // 8 consecutive bad words drop lock
        for (int k = 0; k < 7; k++) cyc(1, 0, 32'hBAD00000 + 32'(k), 0);
        chk("run7", 32'd7, 16'd0, 1'b1);
        cyc(1, 0, 32'hBAD00007, 0);
        chk("loss", 32'd8, 16'd1, 1'b0);
        cyc(1, 0, 32'h31, 0);
        cyc(1, 0, 32'h1234, 0);
        chk("hunt_ignore", 32'd8, 16'd1, 1'b0);

        // Wrap-around
        cyc(1, 1, 32'hFFFFFFFE, 0);
        chk("wrap_sync", 32'd8, 16'd1, 1'b1);
        cyc(1, 0, 32'hFFFFFFFF, 0);
        cyc(1, 0, 32'h00000000, 0);
        cyc(1, 0, 32'h00000001, 0);
        chk("wrap", 32'd8, 16'd1, 1'b1);

        // rx_sync while locked is plain data
        cyc(1, 1, 32'h2, 0);
        chk("sync_locked_match", 32'd8, 16'd1, 1'b1);
        cyc(1, 1, 32'h100, 0);
        chk("sync_locked_bad", 32'd9, 16'd1, 1'b1);
        cyc(1, 0, 32'h4, 0);
        chk("no_realign", 32'd9, 16'd1, 1'b1);

        // clr beats a simultaneous mismatch and clears the run counter
        cyc(1, 0, 32'hBEEF, 1);
        chk("clr_vs_inc", 32'd0, 16'd0, 1'b1);
        for (int k = 0; k < 7; k++) cyc(1, 0, 32'hCAFE0000 + 32'(k), 0);
        chk("clr_run", 32'd7, 16'd0, 1'b1);
        cyc(1, 0, 32'hD, 0);
        chk("run_reset", 32'd7, 16'd0, 1'b1);
        cyc(1, 0, 32'hFFFF, 0);
        chk("pre_reset", 32'd8, 16'd0, 1'b1);

        // Mid-stream reset discards the word and requires a new sync
        user_rst_n = 1'b0;
        cyc(1, 0, 32'hF, 0);
        chk("mid_reset", 32'd0, 16'd0, 1'b0);
        user_rst_n = 1'b1;
        cyc(1, 0, 32'h0, 0);
        cyc(1, 0, 32'h10, 0);
        chk("post_reset_hunt", 32'd0, 16'd0, 1'b0);
        cyc(1, 1, 32'h600, 0);
        cyc(1, 0, 32'h601, 0);
        cyc(1, 0, 32'h777, 0);
        chk("relock", 32'd1, 16'd0, 1'b1);

        // Saturation and clr priority of the shared counter
        sc_inc = 1'b1;
        for (int k = 0; k < 7; k++) cyc(0, 0, 32'h0, 0);
        chk_sat("sat_reach", 3'd7);
        cyc(0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 0);
        chk_sat("sat_hold", 3'd7);
        sc_clr = 1'b1;
        cyc(0, 0, 32'h0, 0);
        chk_sat("sat_clr", 3'd0);
        sc_clr = 1'b0;
        cyc(0, 0, 32'h0, 0);
        chk_sat("sat_inc", 3'd1);
        sc_inc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
